// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MDU_MADD_EN to add the MADD/MADDU multiply-accumulate operations.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    input  logic [3:0]  MDUOp,
    input  logic        Req,
    output logic        busy,
    output logic [31:0] MDOut
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] MulLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
`endif

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     stg_hi_q, stg_hi_d, stg_lo_q, stg_lo_d;
    logic            commit_q, commit_d;

    logic        is_mul, is_div, mul_signed, div_signed;
    logic [63:0] mul_a, mul_b, prod, mul_res;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag, quo, rem;

    // Operation decode and result datapath
    always_comb begin
        is_div     = (MDUOp == OpDiv) || (MDUOp == OpDivu);
        div_signed = (MDUOp == OpDiv);
`ifdef MDU_MADD_EN
        is_mul     = (MDUOp == OpMult) || (MDUOp == OpMultu) ||
                     (MDUOp == OpMadd) || (MDUOp == OpMaddu);
        mul_signed = (MDUOp == OpMult) || (MDUOp == OpMadd);
`else
        is_mul     = (MDUOp == OpMult) || (MDUOp == OpMultu);
        mul_signed = (MDUOp == OpMult);
`endif

        // Low 64 bits of the product of sign-extended operands equal the signed product
        mul_a = {{32{mul_signed & Op1[31]}}, Op1};
        mul_b = {{32{mul_signed & Op2[31]}}, Op2};
        prod  = mul_a * mul_b;

`ifdef MDU_MADD_EN
        if ((MDUOp == OpMadd) || (MDUOp == OpMaddu)) begin
            mul_res = {hi_q, lo_q} + prod;
        end else begin
            mul_res = prod;
        end
`else
        mul_res = prod;
`endif

        // Magnitude division keeps 0x80000000 / -1 well defined
        a_neg = div_signed & Op1[31];
        b_neg = div_signed & Op2[31];
        a_mag = a_neg ? -Op1 : Op1;
        b_mag = b_neg ? -Op2 : Op2;
        b_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_den;
        r_mag = a_mag % b_den;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            stg_hi_q <= '0;
            stg_lo_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stg_hi_d = stg_hi_q;
        stg_lo_d = stg_lo_q;
        commit_d = commit_q;
        case (state_q)
            StIdle: begin
                if (!Req) begin
                    if (is_mul || is_div) begin
                        state_d  = StBusy;
                        cnt_d    = is_div ? DivLoad : MulLoad;
                        stg_hi_d = is_div ? rem : mul_res[63:32];
                        stg_lo_d = is_div ? quo : mul_res[31:0];
                        // A zero divisor still burns the busy window but never commits
                        commit_d = !(is_div && (Op2 == 32'd0));
                    end else if (MDUOp == OpMthi) begin
                        hi_d = Op1;
                    end else if (MDUOp == OpMtlo) begin
                        lo_d = Op1;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (commit_q) begin
                        hi_d = stg_hi_q;
                        lo_d = stg_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StBusy);
        case (MDUOp)
            OpMfhi:  MDOut = hi_q;
            OpMflo:  MDOut = lo_q;
            default: MDOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected reads and busy-window lengths,
// a monitor process pops and checks them as the DUT presents them.
module tb_mdu;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;
    localparam logic [3:0] MADD  = 4'd9;
    localparam logic [3:0] MADDU = 4'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Op1, Op2;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        busy;
    logic [31:0] MDOut;

    int tests = 0;
    int fails = 0;

    logic        rd_en;
    string       rd_name_q[$];
    logic [32:0] rd_exp_q[$];
    string       bz_name_q[$];
    int          bz_exp_q[$];
    int          bz_cnt = 0;

    always #5 clk = ~clk;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Op1  (Op1),
        .Op2  (Op2),
        .MDUOp(MDUOp),
        .Req  (Req),
        .busy (busy),
        .MDOut(MDOut)
    );

    // Monitor: checks queued reads and measures every busy window
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) begin
                tests++;
                if (rd_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: got busy=%0b out=0x%08h, nothing expected",
                             busy, MDOut);
                end else begin
                    string       nm;
                    logic [32:0] ex;
                    nm = rd_name_q.pop_front();
                    ex = rd_exp_q.pop_front();
                    if ({busy, MDOut} !== ex) begin
                        fails++;
                        $display("FAIL %s: got busy=%0b out=0x%08h, expected busy=%0b out=0x%08h",
                                 nm, busy, MDOut, ex[32], ex[31:0]);
                    end
                end
            end
            if (busy === 1'b1) begin
                bz_cnt++;
            end else if (bz_cnt != 0) begin
                tests++;
                if (bz_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_busy: got %0d busy cycles, expected none", bz_cnt);
                end else begin
                    string nm;
                    int    ex;
                    nm = bz_name_q.pop_front();
                    ex = bz_exp_q.pop_front();
                    if (bz_cnt != ex) begin
                        fails++;
                        $display("FAIL %s_busy_len: got %0d cycles, expected %0d", nm, bz_cnt, ex);
                    end
                end
                bz_cnt = 0;
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq);
        MDUOp = op;
        Op1   = a;
        Op2   = b;
        Req   = rq;
        @(posedge clk);
        #1;
        MDUOp = NONE;
        Req   = 1'b0;
    endtask

    task automatic start(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int len);
        bz_name_q.push_back(nm);
        bz_exp_q.push_back(len);
        drive(op, a, b, 1'b0);
    endtask

    task automatic rd(input string nm, input logic [3:0] op, input logic eb,
                      input logic [31:0] ev);
        rd_name_q.push_back(nm);
        rd_exp_q.push_back({eb, ev});
        MDUOp = op;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        MDUOp = NONE;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            @(posedge clk);
            #1;
        end
        if (busy === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%0b after 40 cycles, expected 0", nm, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        Req   = 1'b0;
        Op1   = '0;
        Op2   = '0;
        MDUOp = NONE;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        rd("reset_hi", MFHI, 1'b0, 32'h0);
        rd("reset_lo", MFLO, 1'b0, 32'h0);

        start("mult", MULT, 32'hFFFF_FFFE, 32'd3, 5);
        wait_idle("mult");
        rd("mult_hi", MFHI, 1'b0, 32'hFFFF_FFFF);
        rd("mult_lo", MFLO, 1'b0, 32'hFFFF_FFFA);

        // MT*, restart and operand changes while busy must all be ignored
        start("divu", DIVU, 32'd100, 32'd7, 10);
        drive(MTHI, 32'hDEAD, 32'd0, 1'b0);
        drive(MULT, 32'd3, 32'd3, 1'b0);
        wait_idle("divu");
        rd("divu_hi", MFHI, 1'b0, 32'd2);
        rd("divu_lo", MFLO, 1'b0, 32'd14);

        start("div", DIV, 32'hFFFF_FFF9, 32'd2, 10);
        wait_idle("div");
        rd("div_lo", MFLO, 1'b0, 32'hFFFF_FFFD);
        rd("div_hi", MFHI, 1'b0, 32'hFFFF_FFFF);

        start("div0", DIV, 32'd5, 32'd0, 10);
        wait_idle("div0");
        rd("div0_hi", MFHI, 1'b0, 32'hFFFF_FFFF);
        rd("div0_lo", MFLO, 1'b0, 32'hFFFF_FFFD);

        start("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        wait_idle("divovf");
        rd("divovf_lo", MFLO, 1'b0, 32'h8000_0000);
        rd("divovf_hi", MFHI, 1'b0, 32'h0);

        drive(MULTU, 32'd5, 32'd5, 1'b1);
        rd("req_multu_lo", MFLO, 1'b0, 32'h8000_0000);
        rd("req_multu_hi", MFHI, 1'b0, 32'h0);

        drive(MTLO, 32'h1234, 32'd0, 1'b0);
        rd("mtlo", MFLO, 1'b0, 32'h1234);
        drive(MTHI, 32'h55, 32'd0, 1'b1);
        rd("req_mthi", MFHI, 1'b0, 32'h0);
        drive(MTHI, 32'hABCD, 32'd0, 1'b0);
        rd("mthi", MFHI, 1'b0, 32'hABCD);

        start("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        wait_idle("multu");
        rd("multu_hi", MFHI, 1'b0, 32'hFFFF_FFFE);
        rd("multu_lo", MFLO, 1'b0, 32'h0000_0001);

        // Req arriving during BUSY must not abort the operation
        start("multu_req", MULTU, 32'd7, 32'd6, 5);
        Req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Req = 1'b0;
        wait_idle("multu_req");
        rd("multu_req_lo", MFLO, 1'b0, 32'd42);
        rd("multu_req_hi", MFHI, 1'b0, 32'd0);

        start("div_abort", DIV, 32'd100, 32'd3, 4);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy: got busy=%0b, expected 0", busy);
        end
        #1;
        reset = 1'b0;
        start("post_reset_mult", MULT, 32'd3, 32'hFFFF_FFFC, 5);
        rd("abort_hi", MFHI, 1'b1, 32'h0);
        rd("abort_lo", MFLO, 1'b1, 32'h0);
        wait_idle("post_reset_mult");
        rd("post_reset_hi", MFHI, 1'b0, 32'hFFFF_FFFF);
        rd("post_reset_lo", MFLO, 1'b0, 32'hFFFF_FFF4);

        drive(MTHI, 32'h0, 32'd0, 1'b0);
        drive(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        start("maddu", MADDU, 32'd1, 32'd1, 5);
        wait_idle("maddu");
        rd("maddu_hi", MFHI, 1'b0, 32'd1);
        rd("maddu_lo", MFLO, 1'b0, 32'd0);
        start("madd", MADD, 32'hFFFF_FFFF, 32'd1, 5);
        wait_idle("madd");
        rd("madd_hi", MFHI, 1'b0, 32'd0);
        rd("madd_lo", MFLO, 1'b0, 32'hFFFF_FFFF);
`else
        drive(MADDU, 32'd1, 32'd1, 1'b0);
        rd("maddu_off_hi", MFHI, 1'b0, 32'd0);
        rd("maddu_off_lo", MFLO, 1'b0, 32'hFFFF_FFFF);
`endif

        drive(4'd11, 32'd1, 32'd1, 1'b0);
        rd("op11_none", MFLO, 1'b0, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ((rd_exp_q.size() != 0) || (bz_exp_q.size() != 0)) begin
            fails++;
            $display("FAIL drain: got %0d reads and %0d busy windows left, expected 0 and 0",
                     rd_exp_q.size(), bz_exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of busy cycles for multiply-class operations.
REQ-002 Parameter DIV_CYCLES, default 10: number of busy cycles for divide-class operations.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Op1  input  32  operand A; GRF RD1 (rs).
REQ-006 Op2  input  32  operand B; GRF RD2 (rt).
REQ-007 MDUOp  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; 11-15 treated as NONE.
REQ-008 Req  input  1  CP0 exception request; when high, the current instruction's MDU effect is suppressed.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 MDOut  output  32  HI for MFHI, LO for MFLO, else 0; feeds the GRF write-data mux.

Function
REQ-011 The MDU SHALL have two states: IDLE and BUSY; busy = (state == BUSY).
REQ-012 In IDLE, with Req=0 and MDUOp in {MULT, MULTU, DIV, DIVU, MADD, MADDU}, the rising edge SHALL capture the computed result into internal staging registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-013 In BUSY, the counter SHALL decrement once per cycle; on the edge where it goes from 1 to 0, the MDU SHALL write HI/LO from staging and return to IDLE.
REQ-014 busy SHALL therefore be high for exactly N cycles after the start edge; HI/LO SHALL hold their old values throughout.
REQ-015 In BUSY, start, MT* and MF* requests SHALL be ignored; the controller stalls on busy.
REQ-016 MTHI/MTLO in IDLE with Req=0 SHALL write Op1 into HI/LO at the next edge, with no busy cycles.
REQ-017 MDOut SHALL be combinational from HI/LO and MDUOp, and SHALL not depend on Req.
REQ-018 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Divide by zero SHALL still run DIV_CYCLES busy cycles and SHALL leave HI/LO unchanged.
REQ-022 Req=1 in the same cycle as any start or MT* SHALL suppress it: no state change and busy stays 0.
REQ-023 An operation already in BUSY SHALL complete regardless of Req.
REQ-024 Operands SHALL be sampled only at the start edge; later Op1/Op2 changes SHALL have no effect.

Reset
REQ-025 Asserting reset SHALL asynchronously force state=IDLE, counter=0, HI=0, LO=0, staging=0, busy=0, and MDOut=0.
REQ-026 Reset during BUSY SHALL abort the operation with no HI/LO commit; the first post-reset edge SHALL accept a new start.

Configuration
REQ-027 Macro MDU_MADD_EN defined: MADD/MADDU SHALL compute {HI,LO} + signed/unsigned product, mod 2^64, captured at the start edge, with MULT_CYCLES latency.
REQ-028 Macro MDU_MADD_EN undefined: MDUOp 9 and 10 SHALL be treated as NONE, and no accumulate logic SHALL be synthesized.

Verification
REQ-029 MULT with Op1=0xFFFFFFFE (-2), Op2=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 DIVU with Op1=100, Op2=7 -> busy high 10 cycles, then LO=14, HI=2; MFHI then yields MDOut=2.
REQ-031 DIV with Op1=-7, Op2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divide by zero afterwards -> 10 busy cycles with HI/LO unchanged.
REQ-032 MULTU start with Req=1 -> busy stays 0 and HI/LO unchanged; MTLO with Op1=0x1234 and Req=0 -> LO=0x1234 next cycle.
REQ-033 Reset asserted mid-DIV (cycle 4) -> busy=0 immediately and HI=LO=0; a new MULT on the next edge completes normally.
REQ-034 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU with Op1=1, Op2=1 -> HI=1, LO=0; without the macro the same op leaves HI/LO and busy unchanged.
